tri_feed_ctrl: RTL and testbench

Sequencer that streams a tile of rows from the local operand buffer into the triangular skew FIFO array in front of the systolic array. One `start` pulse triggers the pass: it issues consecutive buffer reads, presents each returned row as an all-lanes beat on the skew FIFO inputs, then appends zero flush beats so the deepest lane drains. `done` pulses when the pass is complete.

---
 rtl/tri_feed_pkg.sv | 34 +++
 rtl/tri_feed_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tri_feed_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_feed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tri_feed_pkg
//  Description : Shared types and constants for the triangular skew-FIFO feed
//                sequencer: FSM state encoding, lane vector type, read-to-beat
//                latency and a saturating increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tri_feed_pkg;

  // Default lane geometry; the sequencer itself is parameterised.
  localparam int DEF_BIT_WIDTH  = 32;
  localparam int DEF_TRI_LENGTH = 16;

  // Cycles from a read strobe to the matching beat on the FIFO inputs:
  // one cycle of buffer latency plus the beat register.
  localparam int FEED_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [DEF_TRI_LENGTH-1:0][DEF_BIT_WIDTH-1:0] lane_vec_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tri_feed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tri_feed_ctrl
//  Description : Streams a tile of rows from the operand buffer into the
//                triangular skew FIFO array. A start pulse latches the base
//                address and row count, issues one buffer read per cycle,
//                registers each returned row into an all-lanes beat, then
//                appends TRI_LENGTH zero flush beats so the deepest lane
//                drains, and finally pulses done.
//  Ports       : clk, rstn (sync, active-low)
//                start, base_addr, num_rows   - pass request
//                busy, done                   - pass status
//                rd_en, rd_addr, rd_data      - operand buffer read port
//                fifo_enable, fifo_data       - skew FIFO inputs
//                cycle_count                  - only with TRI_FEED_PERF_CNT_EN
//  Options     : TRI_FEED_PERF_CNT_EN - adds cycle_count, the busy-cycle count
//                of the last completed pass (saturating, updated on done).
//  Revision    : 1.0  initial release
// ============================================================================
module tri_feed_ctrl
  import tri_feed_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int TRI_LENGTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ROW_W-1:0]                     num_rows,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  input  logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] rd_data,
`ifdef TRI_FEED_PERF_CNT_EN
  output logic [31:0]                          cycle_count,
`endif
  output logic [TRI_LENGTH-1:0]                fifo_enable,
  output logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] fifo_data
);

  // Counts flush beats 0..TRI_LENGTH inclusive.
  localparam int FLUSH_W = $clog2(TRI_LENGTH + 1);

  state_t                              r_state;
  state_t                              w_next;
  logic [ADDR_WIDTH-1:0]               r_addr;
  logic [ROW_W-1:0]                    r_rows_left;
  logic                                r_rd_vld;
  logic [FLUSH_W-1:0]                  r_flush_cnt;
  logic                                r_beat_vld;
  logic [TRI_LENGTH-1:0][BIT_WIDTH-1:0] r_beat_data;

  logic w_last_read;
  logic w_flush_load;
  logic w_flush_full;

  assign w_last_read  = (r_rows_left == ROW_W'(1));
  assign w_flush_full = (r_flush_cnt == FLUSH_W'(TRI_LENGTH));
  // The first DRAIN cycle still carries the last row out of the read
  // pipeline; flush beats are loaded only once that slot is free, which keeps
  // data and flush beats back to back.
  assign w_flush_load = (r_state == DRAIN) && !r_rd_vld && !w_flush_full;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (num_rows != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (w_last_read) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        // Counter full means the final flush beat is on the outputs now.
        if (w_flush_full) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    rd_en       = (r_state == FETCH);
    rd_addr     = (r_state == FETCH) ? r_addr : '0;
    fifo_enable = {TRI_LENGTH{r_beat_vld}};
    fifo_data   = r_beat_data;
  end

  // --------------------------------------------------------------------------
  // Address / row counter, read pipeline, flush counter, beat register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_rows_left <= '0;
      r_rd_vld    <= 1'b0;
      r_flush_cnt <= '0;
      r_beat_vld  <= 1'b0;
      r_beat_data <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_addr      <= base_addr;
        r_rows_left <= num_rows;
      end else if (r_state == FETCH) begin
        // Wraps modulo 2^ADDR_WIDTH by construction.
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_rows_left <= r_rows_left - ROW_W'(1);
      end

      // rd_data is valid the cycle after the strobe.
      r_rd_vld <= (r_state == FETCH);

      if (r_state == DRAIN) begin
        if (w_flush_load) begin
          r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
        end
      end else begin
        r_flush_cnt <= '0;
      end

      // Data and fill beats are held to zero outside beats.
      if (r_rd_vld) begin
        r_beat_vld  <= 1'b1;
        r_beat_data <= rd_data;
      end else if (w_flush_load) begin
        r_beat_vld  <= 1'b1;
        r_beat_data <= '0;
      end else begin
        r_beat_vld  <= 1'b0;
        r_beat_data <= '0;
      end
    end
  end

`ifdef TRI_FEED_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Busy-cycle counter; the done cycle itself is included in the result.
  // --------------------------------------------------------------------------
  logic [31:0] r_busy_cnt;
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy_cnt    <= '0;
      r_cycle_count <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_busy_cnt <= '0;
      end else begin
        r_busy_cnt <= sat_inc32(r_busy_cnt);
      end
      if (r_state == DONE) begin
        r_cycle_count <= sat_inc32(r_busy_cnt);
      end
    end
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tri_feed_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tri_feed_ctrl
//  Description : Scoreboard bench for tri_feed_ctrl (TRI_LENGTH=4). Stimulus
//                pushes expected reads, beats, done pulses and busy cycles;
//                a negedge monitor compares them against the DUT each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tri_feed_ctrl;
  import tri_feed_pkg::*;

  localparam int BW = 32;
  localparam int TL = 4;
  localparam int AW = 8;
  localparam int RW = 8;

  typedef logic [TL-1:0][BW-1:0] row_t;
  typedef struct {int cyc; logic [AW-1:0] addr;} rd_exp_t;
  typedef struct {int cyc; row_t data;} beat_exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [RW-1:0] num_rows = '0;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  row_t          rd_data;
  logic [TL-1:0] fifo_enable;
  row_t          fifo_data;
`ifdef TRI_FEED_PERF_CNT_EN
  logic [31:0]   cycle_count;
`endif

  tri_feed_ctrl #(
    .BIT_WIDTH (BW),
    .TRI_LENGTH(TL),
    .ADDR_WIDTH(AW),
    .ROW_W     (RW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
`ifdef TRI_FEED_PERF_CNT_EN
    .cycle_count(cycle_count),
`endif
    .fifo_enable(fifo_enable),
    .fifo_data  (fifo_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  rd_exp_t   rd_q[$];
  beat_exp_t beat_q[$];
  int        done_q[$];
  bit        busy_map[int];
  bit        mon_en = 1'b0;

  // Buffer contents: every lane tagged with its address and lane index.
  function automatic row_t row_of(input logic [AW-1:0] a);
    row_t r;
    for (int i = 0; i < TL; i++) r[i] = {a, 8'(i), 8'hC3, ~a};
    return r;
  endfunction

  // Buffer model: one-cycle read latency, junk when not strobed.
  always @(posedge clk) rd_data <= rd_en ? row_of(rd_addr) : {TL{32'hBAD0_BAD0}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle each output is either an expected event or quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        check("rd_en", 128'(rd_en), 128'(1));
        check("rd_addr", 128'(rd_addr), 128'(rd_q[0].addr));
        void'(rd_q.pop_front());
      end else begin
        check("rd_en_quiet", 128'(rd_en), 128'(0));
      end
      if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
        check("fifo_enable", 128'(fifo_enable), 128'({TL{1'b1}}));
        check("fifo_data", 128'(fifo_data), 128'(beat_q[0].data));
        void'(beat_q.pop_front());
      end else begin
        check("fifo_enable_quiet", 128'(fifo_enable), 128'(0));
        check("fifo_data_quiet", 128'(fifo_data), 128'(0));
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        check("done", 128'(done), 128'(1));
        void'(done_q.pop_front());
      end else begin
        check("done_quiet", 128'(done), 128'(0));
      end
      check("busy", 128'(busy), 128'(busy_map.exists(cyc)));
    end
  end

  // Advance to the given cycle, positioned just after its opening edge.
  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a start in the current cycle (cycle 0 of the pass) and queue the
  // hand-derived response: reads in 1..N, data beats in 3..N+2, flush beats
  // in N+3..N+2+TL, done in N+3+TL (or cycle 1 when N=0).
  task automatic launch(input logic [AW-1:0] b, input int n, output int done_cyc);
    int c0;
    c0 = cyc;
    start = 1'b1;
    base_addr = b;
    num_rows = RW'(n);
    for (int k = 0; k < n; k++) begin
      rd_q.push_back('{c0 + 1 + k, b + AW'(k)});
      beat_q.push_back('{c0 + 1 + FEED_LATENCY + k, row_of(b + AW'(k))});
    end
    if (n > 0) begin
      for (int j = 0; j < TL; j++) beat_q.push_back('{c0 + n + 3 + j, row_t'(0)});
      done_cyc = c0 + n + 3 + TL;
    end else begin
      done_cyc = c0 + 1;
    end
    done_q.push_back(done_cyc);
    for (int c = c0 + 1; c <= done_cyc; c++) busy_map[c] = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 8'hAA;
    num_rows = 8'h55;
  endtask

  task automatic check_perf(input int exp);
`ifdef TRI_FEED_PERF_CNT_EN
    check("cycle_count", 128'(cycle_count), 128'(exp));
`else
    if (exp < 0) $display("unused %0d", exp);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_rd_en"}, 128'(rd_en), 128'(0));
    check({tag, "_rd_addr"}, 128'(rd_addr), 128'(0));
    check({tag, "_fifo_enable"}, 128'(fifo_enable), 128'(0));
    check({tag, "_fifo_data"}, 128'(fifo_data), 128'(0));
  endtask

  initial begin
    int d, d2, c0;
    // Reset, then idle for 10 cycles with start low.
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check_perf(0);
    mon_en = 1'b1;
    rstn = 1'b1;
    wait_cyc(cyc + 10);

    // 3-row pass at 0x10: busy 1..10, done at 10.
    launch(8'h10, 3, d);
    wait_cyc(d + 1);
    check_perf(10);

    // Address wrap: 0xFE, 0xFF, 0x00, 0x01.
    launch(8'hFE, 4, d);
    wait_cyc(d + 1);
    check_perf(11);

    // Empty pass: done in cycle 1, no reads or beats.
    launch(8'h40, 0, d);
    wait_cyc(d + 1);
    check_perf(1);

    // Start during FETCH is ignored; start right after done is accepted.
    launch(8'h20, 2, d);
    start = 1'b1;
    base_addr = 8'h80;
    num_rows = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc(d + 1);
    launch(8'h30, 1, d2);
    wait_cyc(d2 + 1);
    check_perf(8);

    // Reset during DRAIN of a 3-row pass, then a fresh pass.
    wait_cyc(cyc + 2);
    c0 = cyc;
    launch(8'h50, 3, d);
    wait_cyc(c0 + 6);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rd_q.delete();
    beat_q.delete();
    done_q.delete();
    for (int c = c0 + 7; c <= d; c++) busy_map.delete(c);
    check_all_zero("mid_reset");
    check_perf(0);
    rstn = 1'b1;
    wait_cyc(cyc + 2);
    launch(8'h60, 3, d);
    wait_cyc(d + 1);
    check_perf(10);

    wait_cyc(cyc + 5);
    check("rd_q_left", 128'(rd_q.size()), 128'(0));
    check("beat_q_left", 128'(beat_q.size()), 128'(0));
    check("done_q_left", 128'(done_q.size()), 128'(0));
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
